// File: rtl/teclado_entrada_ctrl.sv
// teclado_entrada_ctrl
// Builds a multi-digit BCD entry from debounced keypad presses. Digits are
// shifted in from the right, 'A' deletes the last digit, '*' clears the entry
// and '#' commits it to `valor` with a one-cycle `pronto` strobe. A non-empty
// entry left idle for TIMEOUT_CYC cycles is discarded with a `timeout` strobe.
//
// Handshake: the input is a level (`key_valid` high while a key is held). A
// press is accepted only on its rising edge, so every strobe output
// (`pronto`, `erro`, `timeout`) is a single-cycle, mutually exclusive pulse
// with no back-pressure; downstream logic must sample it in that cycle.
//
// `estado` exposes the FSM state (0 = VAZIO, 1 = DIGITANDO, 2 = CONFIRMA).

module teclado_entrada_ctrl #(
    parameter int MAX_DIG     = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [3:0]           bcd_in,
    output logic [4*MAX_DIG-1:0] entrada,
    output logic [2:0]           n_dig,
    output logic [4*MAX_DIG-1:0] valor,
    output logic                 pronto,
    output logic                 erro,
    output logic                 timeout,
    output logic [1:0]           estado
);

    localparam int              W        = 4 * MAX_DIG;
    localparam int              CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      N_MAX    = 3'(MAX_DIG);

    typedef enum logic [1:0] {
        VAZIO     = 2'd0,
        DIGITANDO = 2'd1,
        CONFIRMA  = 2'd2
    } estado_t;

    estado_t         state_q, state_d;
    logic            kv_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    entrada_d, valor_d, shifted;
    logic [2:0]      n_dig_d;
    logic            pronto_d, erro_d, timeout_d;

    logic            press, press_ok;
    logic            is_dig, is_bs, is_clr, is_ok;
    logic            dig_ok, bs_ok, clr_ok, ok_ok, err_ok, to_hit;

    assign estado = state_q;

    // Press decode: rising edge of key_valid, ignored during the commit cycle.
    assign press    = key_valid && !kv_d;
    assign press_ok = press && (state_q != CONFIRMA);

    assign is_dig = (bcd_in <= 4'h9);
    assign is_bs  = (bcd_in == 4'hA);
    assign is_clr = (bcd_in == 4'hE);
    assign is_ok  = (bcd_in == 4'hF);

    // A full entry silently drops further digits; edits on an empty entry are no-ops.
    assign dig_ok = press_ok && is_dig && (n_dig < N_MAX);
    assign bs_ok  = press_ok && is_bs  && (n_dig != 3'd0);
    assign clr_ok = press_ok && is_clr && (n_dig != 3'd0);
    assign ok_ok  = press_ok && is_ok  && (n_dig != 3'd0);
    assign err_ok = press_ok && is_ok  && (n_dig == 3'd0);

    // Any accepted press in the expiry cycle takes precedence over the timeout.
    assign to_hit = (state_q == DIGITANDO) && (cnt_q == '0) && !press;

    // New digit enters at the low nibble; the oldest digit falls off the top.
    if (MAX_DIG > 1) begin : g_shift
        assign shifted = {entrada[W-5:0], bcd_in};
    end else begin : g_shift1
        assign shifted = bcd_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= VAZIO;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VAZIO: begin
                if (dig_ok) state_d = DIGITANDO;
            end
            DIGITANDO: begin
                if (ok_ok)
                    state_d = CONFIRMA;
                else if (clr_ok || (bs_ok && n_dig == 3'd1) || to_hit)
                    state_d = VAZIO;
            end
            CONFIRMA: state_d = VAZIO;
            default:  state_d = VAZIO;
        endcase
    end

    // Output/datapath next values: entry editing, commit, strobes and idle counter.
    always_comb begin
        entrada_d = entrada;
        n_dig_d   = n_dig;
        valor_d   = valor;
        pronto_d  = 1'b0;
        erro_d    = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        if (state_q == CONFIRMA) begin
            valor_d   = entrada;
            pronto_d  = 1'b1;
            entrada_d = '0;
            n_dig_d   = 3'd0;
        end else begin
            if (dig_ok) begin
                entrada_d = shifted;
                n_dig_d   = n_dig + 3'd1;
            end else if (bs_ok) begin
                entrada_d = entrada >> 4;
                n_dig_d   = n_dig - 3'd1;
            end else if (clr_ok) begin
                entrada_d = '0;
                n_dig_d   = 3'd0;
            end else if (err_ok) begin
                erro_d = 1'b1;
            end else if (to_hit) begin
                entrada_d = '0;
                n_dig_d   = 3'd0;
                timeout_d = 1'b1;
            end
            if (dig_ok || bs_ok || clr_ok)
                cnt_d = CNT_LOAD;
            else if (state_q == DIGITANDO && cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
        end
    end

    // Datapath registers; reset also discards a commit that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            kv_d    <= 1'b0;
            cnt_q   <= CNT_LOAD;
            entrada <= '0;
            n_dig   <= 3'd0;
            valor   <= '0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            kv_d    <= key_valid;
            cnt_q   <= cnt_d;
            entrada <= entrada_d;
            n_dig   <= n_dig_d;
            valor   <= valor_d;
            pronto  <= pronto_d;
            erro    <= erro_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_teclado_entrada_ctrl.sv
// Directed testbench for teclado_entrada_ctrl (MAX_DIG=4, TIMEOUT_CYC=20).
// Inputs change and outputs are sampled 1 ns after the rising edge.

module tb_teclado_entrada_ctrl;

    localparam int MAX_DIG = 4;
    localparam int TO_CYC  = 20;
    localparam int W       = 4 * MAX_DIG;

    localparam logic [1:0] S_VAZIO = 2'd0;
    localparam logic [1:0] S_DIG   = 2'd1;
    localparam logic [1:0] S_CONF  = 2'd2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [3:0]   bcd_in = 4'h0;
    logic [W-1:0] entrada, valor;
    logic [2:0]   n_dig;
    logic         pronto, erro, timeout;
    logic [1:0]   estado;

    int n_chk = 0;
    int n_pass = 0;

    // Pulse monitor counts.
    int pronto_n = 0, erro_n = 0, to_n = 0, excl_bad = 0, wide_bad = 0;
    logic pronto_p = 1'b0, erro_p = 1'b0, to_p = 1'b0;

    teclado_entrada_ctrl #(.MAX_DIG(MAX_DIG), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .bcd_in(bcd_in),
        .entrada(entrada), .n_dig(n_dig), .valor(valor),
        .pronto(pronto), .erro(erro), .timeout(timeout), .estado(estado)
    );

    // Clock.
    always #5 clk = ~clk;

    // Strobe monitor: counts pulses, flags overlap and pulses wider than one cycle.
    always @(negedge clk) begin
        if (pronto)  pronto_n++;
        if (erro)    erro_n++;
        if (timeout) to_n++;
        if ((int'(pronto) + int'(erro) + int'(timeout)) > 1) excl_bad++;
        if ((pronto && pronto_p) || (erro && erro_p) || (timeout && to_p)) wide_bad++;
        pronto_p = pronto;
        erro_p   = erro;
        to_p     = timeout;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k, input int hi, input int lo);
        bcd_in    = k;
        key_valid = 1'b1;
        repeat (hi) tick();
        key_valid = 1'b0;
        repeat (lo) tick();
    endtask

    // '#' with a non-empty entry: CONFIRMA next cycle, pronto/valor the cycle after.
    task automatic do_commit(input string tag, input logic [W-1:0] exp);
        bcd_in    = 4'hF;
        key_valid = 1'b1;
        tick();
        check_eq({tag, "_conf_state"}, 32'(estado), 32'(S_CONF));
        check_eq({tag, "_pronto_early"}, 32'(pronto), 32'd0);
        tick();
        check_eq({tag, "_pronto"}, 32'(pronto), 32'd1);
        check_eq({tag, "_valor"}, 32'(valor), 32'(exp));
        check_eq({tag, "_ndig0"}, 32'(n_dig), 32'd0);
        check_eq({tag, "_entrada0"}, 32'(entrada), 32'd0);
        tick();
        check_eq({tag, "_pronto_end"}, 32'(pronto), 32'd0);
        repeat (2) tick();
        key_valid = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int p0, e0, t0, first_to;

        // Reset.
        rst = 1'b1;
        key_valid = 1'b0;
        repeat (3) tick();
        check_eq("rst_entrada", 32'(entrada), 32'd0);
        check_eq("rst_ndig", 32'(n_dig), 32'd0);
        check_eq("rst_valor", 32'(valor), 32'd0);
        check_eq("rst_strobes", {29'd0, pronto, erro, timeout}, 32'd0);
        check_eq("rst_state", 32'(estado), 32'(S_VAZIO));
        rst = 1'b0;
        repeat (2) tick();

        // Basic commit: 1, 2, 3, '#'.
        bcd_in = 4'h1;
        key_valid = 1'b1;
        tick();
        check_eq("basic_lat_ndig", 32'(n_dig), 32'd1);
        check_eq("basic_lat_state", 32'(estado), 32'(S_DIG));
        repeat (4) tick();
        key_valid = 1'b0;
        repeat (5) tick();
        press_key(4'h2, 5, 5);
        check_eq("basic_ndig2", 32'(n_dig), 32'd2);
        press_key(4'h3, 5, 5);
        check_eq("basic_ndig3", 32'(n_dig), 32'd3);
        check_eq("basic_entrada", 32'(entrada), 32'h0123);
        p0 = pronto_n;
        do_commit("basic", 16'h0123);
        check_eq("basic_pronto_cnt", 32'(pronto_n - p0), 32'd1);

        // Single acceptance on a held key (held past the idle limit).
        t0 = to_n;
        bcd_in = 4'h7;
        key_valid = 1'b1;
        repeat (10) tick();
        check_eq("hold_ndig", 32'(n_dig), 32'd1);
        check_eq("hold_entrada", 32'(entrada), 32'h0007);
        repeat (40) tick();
        check_eq("hold_ndig_after", 32'(n_dig), 32'd0);
        check_eq("hold_to_cnt", 32'(to_n - t0), 32'd1);
        key_valid = 1'b0;
        repeat (5) tick();

        // Editing: 4, 5, 'A', 6, '#'.
        press_key(4'h4, 5, 5);
        press_key(4'h5, 5, 5);
        check_eq("edit_45", 32'(entrada), 32'h0045);
        press_key(4'hA, 5, 5);
        check_eq("edit_bs", 32'(entrada), 32'h0004);
        check_eq("edit_bs_ndig", 32'(n_dig), 32'd1);
        press_key(4'h6, 5, 5);
        do_commit("edit", 16'h0046);

        // 9, '*', '#': clear then error on empty commit.
        p0 = pronto_n;
        press_key(4'h9, 5, 5);
        press_key(4'hE, 5, 5);
        check_eq("clr_entrada", 32'(entrada), 32'd0);
        check_eq("clr_state", 32'(estado), 32'(S_VAZIO));
        e0 = erro_n;
        bcd_in = 4'hF;
        key_valid = 1'b1;
        tick();
        check_eq("err_pulse", 32'(erro), 32'd1);
        check_eq("err_state", 32'(estado), 32'(S_VAZIO));
        tick();
        check_eq("err_end", 32'(erro), 32'd0);
        repeat (3) tick();
        key_valid = 1'b0;
        repeat (5) tick();
        check_eq("err_cnt", 32'(erro_n - e0), 32'd1);
        check_eq("err_valor_kept", 32'(valor), 32'h0046);
        check_eq("err_no_pronto", 32'(pronto_n - p0), 32'd0);

        // Backspace to empty, then no-op keys on an empty entry.
        press_key(4'h7, 5, 5);
        press_key(4'hA, 5, 5);
        check_eq("bs_empty_state", 32'(estado), 32'(S_VAZIO));
        press_key(4'hA, 5, 5);
        press_key(4'hB, 5, 5);
        check_eq("noop_ndig", 32'(n_dig), 32'd0);
        check_eq("noop_entrada", 32'(entrada), 32'd0);

        // Overflow: fifth digit ignored; '#' lands exactly on counter expiry.
        t0 = to_n;
        press_key(4'h1, 5, 5);
        press_key(4'h2, 5, 5);
        press_key(4'h3, 5, 5);
        press_key(4'h4, 5, 5);
        press_key(4'h5, 5, 5);
        check_eq("ovf_entrada", 32'(entrada), 32'h1234);
        check_eq("ovf_ndig", 32'(n_dig), 32'd4);
        do_commit("ovf", 16'h1234);
        check_eq("ovf_no_timeout", 32'(to_n - t0), 32'd0);

        // Timeout: exact latency from the acceptance cycle.
        t0 = to_n;
        first_to = 0;
        bcd_in = 4'h8;
        key_valid = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 3) key_valid = 1'b0;
            if (timeout && first_to == 0) first_to = k;
        end
        check_eq("to_latency", 32'(first_to), 32'(TO_CYC + 1));
        check_eq("to_cnt", 32'(to_n - t0), 32'd1);
        check_eq("to_ndig", 32'(n_dig), 32'd0);
        check_eq("to_state", 32'(estado), 32'(S_VAZIO));
        check_eq("to_valor_kept", 32'(valor), 32'h1234);

        // 8 then 3 at 15-cycle spacing: no timeout in between.
        t0 = to_n;
        press_key(4'h8, 5, 10);
        press_key(4'h3, 5, 5);
        check_eq("to_gap_cnt", 32'(to_n - t0), 32'd0);
        check_eq("to_gap_entrada", 32'(entrada), 32'h0083);
        press_key(4'hE, 5, 5);
        check_eq("to_gap_clear", 32'(n_dig), 32'd0);

        // Reset mid-entry.
        press_key(4'h1, 5, 5);
        press_key(4'h2, 5, 5);
        check_eq("rmid_ndig_pre", 32'(n_dig), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rmid_entrada", 32'(entrada), 32'd0);
        check_eq("rmid_ndig", 32'(n_dig), 32'd0);
        check_eq("rmid_valor", 32'(valor), 32'd0);
        check_eq("rmid_state", 32'(estado), 32'(S_VAZIO));

        // Reset during CONFIRMA discards the pending commit.
        press_key(4'h5, 5, 5);
        p0 = pronto_n;
        bcd_in = 4'hF;
        key_valid = 1'b1;
        tick();
        check_eq("rconf_state_pre", 32'(estado), 32'(S_CONF));
        rst = 1'b1;
        key_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rconf_pronto", 32'(pronto), 32'd0);
        check_eq("rconf_valor", 32'(valor), 32'd0);
        check_eq("rconf_ndig", 32'(n_dig), 32'd0);
        check_eq("rconf_state", 32'(estado), 32'(S_VAZIO));
        repeat (4) tick();
        check_eq("rconf_no_pronto", 32'(pronto_n - p0), 32'd0);

        // Normal operation resumes after reset.
        press_key(4'h2, 5, 5);
        do_commit("post_rst", 16'h0002);

        // Strobe sanity over the whole run.
        check_eq("strobe_exclusive", 32'(excl_bad), 32'd0);
        check_eq("strobe_width", 32'(wide_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
